// File: rtl/decode_scoreboard.sv
// Decode stage with architectural register file, pending-write scoreboard,
// write-back bypass, flush and a registered ID/EX output.
//
// Handshake: a transfer into ID/EX happens on a posedge where id_ready=1
// (if_valid=1, no hazard, no flush, and ID/EX empty or ex_ready=1); a
// transfer out of ID/EX happens on a posedge where ex_valid=1 and ex_ready=1.
// While ex_valid=1 and ex_ready=0 every ex_* output holds.
module decode_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_ir,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [31:0]       ex_ir,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  input  logic              wb_valid,
  input  logic [31:0]       wb_ir,
  input  logic [DATA_W-1:0] wb_res
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [NUM_REGS-1:0] wb_clr;
  logic [NUM_REGS-1:0] eff_pend;

  // ALU or LW with an implemented, non-zero destination.
  function automatic logic is_writer(input logic [31:0] ir);
    logic [5:0] op;
    op = ir[31:26];
    return ((op[5:4] == 2'b00) || (op == 6'b010001)) &&
           (ir[25:21] != 5'd0) && (int'(ir[25:21]) < NUM_REGS);
  endfunction

  logic [5:0] op;
  logic [4:0] ri, rj, rk;
  logic       is_beq, is_jmp, is_other, is_alu, is_lw, dec_wr;
  logic       use_i, use_j, use_k;
  logic       wb_we;
  logic [4:0] wb_dst;
  logic [4:0] ex_ri;
  logic       hazard;
  logic [DATA_W-1:0] rd_i, rd_j, rd_k;
  logic [DATA_W-1:0] dec_a, dec_b, dec_imm;

  assign op       = if_ir[31:26];
  assign ri       = if_ir[25:21];
  assign rj       = if_ir[20:16];
  assign rk       = if_ir[15:11];
  assign is_alu   = (op[5:4] == 2'b00);
  assign is_lw    = (op == 6'b010001);
  assign is_beq   = (op == 6'b100000);
  assign is_jmp   = (op == 6'b100001);
  assign is_other = ~is_alu & ~is_lw & ~is_beq & ~is_jmp;
  assign dec_wr   = is_writer(if_ir);
  // Ri is checked as a source (BEQ/OTHER) or as a WAW destination (writers).
  assign use_i    = is_beq | is_other | dec_wr;
  assign use_j    = ~is_jmp;
  assign use_k    = is_alu;
  assign wb_we    = wb_valid & is_writer(wb_ir);
  assign wb_dst   = wb_ir[25:21];
  assign ex_ri    = ex_ir[25:21];

  // Pending bits as seen this cycle: a write-back in flight already counts as done.
  always_comb begin
    wb_clr = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_we && (int'(wb_dst) == i)) wb_clr[i] = 1'b1;
    end
    eff_pend = pend & ~wb_clr;
  end

  // RAW/WAW interlock against the scoreboard; register 0 is never a hazard.
  always_comb begin
    hazard = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (eff_pend[i] && ((use_i && int'(ri) == i) ||
                          (use_j && int'(rj) == i) ||
                          (use_k && int'(rk) == i))) begin
        hazard = 1'b1;
      end
    end
    if (!if_valid) hazard = 1'b0;
  end

  assign id_ready = if_valid & ~hazard & ~flush & (~ex_valid | ex_ready);

  // Operand reads with write-back bypass; unimplemented indices read 0.
  always_comb begin
    rd_i = '0;
    rd_j = '0;
    rd_k = '0;
    if (ri != 5'd0 && int'(ri) < NUM_REGS)
      rd_i = (wb_we && wb_dst == ri) ? wb_res : regs[ri];
    if (rj != 5'd0 && int'(rj) < NUM_REGS)
      rd_j = (wb_we && wb_dst == rj) ? wb_res : regs[rj];
    if (rk != 5'd0 && int'(rk) < NUM_REGS)
      rd_k = (wb_we && wb_dst == rk) ? wb_res : regs[rk];
  end

  // Operand and immediate mapping by instruction class.
  always_comb begin
    dec_a   = is_beq ? (rd_i ^ rd_j) : (is_jmp ? '0 : rd_j);
    dec_b   = is_alu ? rd_k : rd_i;
    dec_imm = is_jmp ? {{(DATA_W-26){if_ir[25]}}, if_ir[25:0]}
                     : {{(DATA_W-16){if_ir[15]}}, if_ir[15:0]};
  end

  // Next scoreboard: write-back clear, flush clear, then issue set (set wins).
  always_comb begin
    pend_nxt = pend & ~wb_clr;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (flush && ex_valid && is_writer(ex_ir) && int'(ex_ri) == i) pend_nxt[i] = 1'b0;
      if (id_ready && dec_wr && int'(ri) == i) pend_nxt[i] = 1'b1;
    end
  end

  // Register file and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (wb_we) regs[wb_dst] <= wb_res;
      pend <= pend_nxt;
    end
  end

  // ID/EX register: flush beats issue, issue beats bubble, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ir    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (id_ready) begin
      ex_valid <= 1'b1;
      ex_ir    <= if_ir;
      ex_a     <= dec_a;
      ex_b     <= dec_b;
      ex_imm   <= dec_imm;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed scenarios followed by random traffic,
// each cycle compared against a reference model built from instruction-class
// rules, a register array and a list of outstanding writer destinations.
module tb_decode_scoreboard;
  localparam int DW = 32;
  localparam int NR = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_valid = 1'b0;
  logic [31:0]   if_ir = '0;
  logic          id_ready;
  logic          flush = 1'b0;
  logic          ex_ready = 1'b1;
  logic          ex_valid;
  logic [31:0]   ex_ir;
  logic [DW-1:0] ex_a, ex_b, ex_imm;
  logic          wb_valid = 1'b0;
  logic [31:0]   wb_ir = '0;
  logic [DW-1:0] wb_res = '0;

  decode_scoreboard #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ir(if_ir),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_ir(ex_ir), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .wb_valid(wb_valid), .wb_ir(wb_ir), .wb_res(wb_res)
  );

  int total = 0;
  int passed = 0;
  logic seen_ready;

  // scoreboard / reference model state
  logic [DW-1:0] m_regs [NR];
  int            m_out[$];
  logic          m_ex_valid;
  logic [31:0]   m_ex_ir;
  logic [DW-1:0] m_ex_a, m_ex_b, m_ex_imm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // 0 ALU, 1 LW, 2 BEQ, 3 JMP, 4 OTHER
  function automatic int klass(input logic [31:0] ir);
    if (ir[31:30] == 2'b00) return 0;
    if (ir[31:26] == 6'b010001) return 1;
    if (ir[31:26] == 6'b100000) return 2;
    if (ir[31:26] == 6'b100001) return 3;
    return 4;
  endfunction

  function automatic bit m_writer(input logic [31:0] ir);
    int d;
    d = int'(ir[25:21]);
    return (klass(ir) <= 1) && d != 0 && d < NR;
  endfunction

  function automatic logic [DW-1:0] m_rd(input int r, input bit wbw, input int wd,
                                         input logic [DW-1:0] wres);
    if (r == 0 || r >= NR) return '0;
    if (wbw && wd == r) return wres;
    return m_regs[r];
  endfunction

  function automatic bit m_pending(input int r, input bit wbw, input int wd);
    foreach (m_out[i]) if (m_out[i] == r && !(wbw && wd == r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic rm_out(input int r);
    for (int i = m_out.size() - 1; i >= 0; i--) if (m_out[i] == r) m_out.delete(i);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_out.delete();
    m_ex_valid = 1'b0;
    m_ex_ir = '0;
    m_ex_a = '0;
    m_ex_b = '0;
    m_ex_imm = '0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input int ri, input int rj, input int rk);
    return {op, 5'(ri), 5'(rj), 5'(rk), 11'h000};
  endfunction

  task automatic check_outputs();
    logic [NR-1:0] m;
    m = '0;
    foreach (m_out[i]) m[m_out[i]] = 1'b1;
    chk("ex_valid", 64'(ex_valid), 64'(m_ex_valid));
    chk("ex_ir", 64'(ex_ir), 64'(m_ex_ir));
    chk("ex_a", 64'(ex_a), 64'(m_ex_a));
    chk("ex_b", 64'(ex_b), 64'(m_ex_b));
    chk("ex_imm", 64'(ex_imm), 64'(m_ex_imm));
    chk("pend", 64'(dut.pend), 64'(m));
  endtask

  // driver: inputs are already applied at the negedge; evaluate, clock, compare
  task automatic cycle();
    bit wbw, haz, rdy;
    int wd, k, ri, rj, rk;
    int srcs[$];
    logic [DW-1:0] a, b, imm;
    #1;
    wbw = wb_valid && m_writer(wb_ir);
    wd  = int'(wb_ir[25:21]);
    k   = klass(if_ir);
    ri  = int'(if_ir[25:21]);
    rj  = int'(if_ir[20:16]);
    rk  = int'(if_ir[15:11]);
    case (k)
      0: srcs = '{rj, rk};
      1: srcs = '{rj};
      2: srcs = '{ri, rj};
      3: srcs = {};
      default: srcs = '{rj, ri};
    endcase
    if (m_writer(if_ir)) srcs.push_back(ri);
    haz = 1'b0;
    foreach (srcs[i]) if (srcs[i] != 0 && m_pending(srcs[i], wbw, wd)) haz = 1'b1;
    rdy = if_valid && !haz && !flush && (!m_ex_valid || ex_ready);
    seen_ready = id_ready;
    chk("id_ready", 64'(id_ready), 64'(rdy));
    if (k == 2) a = m_rd(ri, wbw, wd, wb_res) ^ m_rd(rj, wbw, wd, wb_res);
    else if (k == 3) a = '0;
    else a = m_rd(rj, wbw, wd, wb_res);
    b = (k == 0) ? m_rd(rk, wbw, wd, wb_res) : m_rd(ri, wbw, wd, wb_res);
    if (k == 3) imm = DW'(signed'(if_ir[25:0]));
    else imm = DW'(signed'(if_ir[15:0]));
    @(posedge clk);
    if (wbw) begin
      m_regs[wd] = wb_res;
      rm_out(wd);
    end
    if (flush) begin
      if (m_ex_valid && m_writer(m_ex_ir)) rm_out(int'(m_ex_ir[25:21]));
      m_ex_valid = 1'b0;
    end else if (rdy) begin
      m_ex_valid = 1'b1;
      m_ex_ir = if_ir;
      m_ex_a = a;
      m_ex_b = b;
      m_ex_imm = imm;
      if (m_writer(if_ir)) m_out.push_back(ri);
    end else if (ex_ready) begin
      m_ex_valid = 1'b0;
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0;
    if_ir = '0;
    flush = 1'b0;
    ex_ready = 1'b1;
    wb_valid = 1'b0;
    wb_ir = '0;
    wb_res = '0;
  endtask

  task automatic wb_write(input int r, input logic [DW-1:0] v);
    idle_inputs();
    wb_valid = 1'b1;
    wb_ir = mk(6'b000000, r, 0, 0);
    wb_res = v;
    cycle();
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // write-back then dependent-free ALU reading the written register
    wb_write(3, 32'h0000_00AA);
    idle_inputs();
    if_valid = 1'b1;
    if_ir = mk(6'b000000, 4, 3, 3);
    cycle();
    chk("alu_a", 64'(ex_a), 64'h0AA);
    chk("alu_b", 64'(ex_b), 64'h0AA);
    chk("alu_pend4", 64'(dut.pend[4]), 64'h1);

    // LW r7, then a reader of r7 stalls until write-back bypass
    if_ir = mk(6'b010001, 7, 0, 0);
    cycle();
    if_ir = mk(6'b000000, 8, 7, 0);
    cycle();
    chk("raw_stall", 64'(seen_ready), 64'h0);
    wb_valid = 1'b1;
    wb_ir = mk(6'b010001, 7, 0, 0);
    wb_res = 32'h0000_1234;
    cycle();
    chk("bypass_ready", 64'(seen_ready), 64'h1);
    chk("bypass_a", 64'(ex_a), 64'h1234);

    // BEQ xor of r2=5 and r6=3
    wb_write(2, 32'd5);
    wb_write(6, 32'd3);
    idle_inputs();
    if_valid = 1'b1;
    if_ir = mk(6'b100000, 2, 6, 0);
    cycle();
    chk("beq_a", 64'(ex_a), 64'h6);

    // JMP with all-ones target field
    if_ir = {6'b100001, 26'h3FF_FFFF};
    cycle();
    chk("jmp_a", 64'(ex_a), 64'h0);
    chk("jmp_imm", 64'(ex_imm), 64'hFFFF_FFFF);

    // back-pressure: ID/EX holds for three cycles
    ex_ready = 1'b0;
    if_ir = mk(6'b000000, 10, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_ready", 64'(seen_ready), 64'h0);
      chk("hold_ir", 64'(ex_ir), 64'({6'b100001, 26'h3FF_FFFF}));
      chk("hold_imm", 64'(ex_imm), 64'hFFFF_FFFF);
    end

    // flush kills a writer of r9 in ID/EX and releases its pend bit
    ex_ready = 1'b1;
    if_ir = mk(6'b000000, 9, 1, 1);
    cycle();
    chk("wr9_pend", 64'(dut.pend[9]), 64'h1);
    flush = 1'b1;
    if_ir = mk(6'b000000, 11, 9, 0);
    cycle();
    chk("flush_valid", 64'(ex_valid), 64'h0);
    chk("flush_pend9", 64'(dut.pend[9]), 64'h0);
    flush = 1'b0;
    cycle();
    chk("post_flush_ready", 64'(seen_ready), 64'h1);

    // writes to r0 are ignored
    wb_write(0, 32'hFFFF_FFFF);
    idle_inputs();
    if_valid = 1'b1;
    if_ir = mk(6'b000000, 12, 0, 0);
    cycle();
    chk("r0_read", 64'(ex_a), 64'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      int r;
      idle_inputs();
      case ($urandom_range(0, 4))
        0: op = {2'b00, 4'($urandom)};
        1: op = 6'b010001;
        2: op = 6'b100000;
        3: op = 6'b100001;
        default: op = 6'($urandom);
      endcase
      if_valid = ($urandom_range(0, 3) != 0);
      if_ir = {op, 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
               5'($urandom_range(0, 9)), 11'($urandom)};
      if ($urandom_range(0, 9) == 0) if_ir[25:21] = 5'd31;
      flush = ($urandom_range(0, 19) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        if (m_out.size() != 0 && $urandom_range(0, 3) != 0)
          r = m_out[$urandom_range(0, m_out.size() - 1)];
        else
          r = $urandom_range(0, 31);
        wb_valid = 1'b1;
        wb_ir = mk($urandom_range(0, 1) ? 6'b010001 : 6'b000011, r, 0, 0);
        wb_res = $urandom;
      end
      cycle();
    end

    // asynchronous reset in the middle of a cycle
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    if_valid = 1'b1;
    if_ir = mk(6'b000000, 12, 5, 5);
    cycle();
    chk("reset_r5_a", 64'(ex_a), 64'h0);
    chk("reset_r5_valid", 64'(ex_valid), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
